etapa_decodificacion: RTL and testbench
=======================================

ETAPA_DECODIFICACION -- requirements
Module: etapa_decodificacion

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock, all state on rising edge.
REQ-002 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-003 SHALL have ports in_valid (input, 1), in_ready (output, 1), in_instr (input, 32) and in_pc (input, 32): instruction from fetch.
REQ-004 SHALL have ports addr1 and addr2 (output, 5 each): rs1/rs2 read addresses to conjunto_reg__32x32.
REQ-005 SHALL have ports datos1 and datos2 (input, 32 each): register-file read data, same cycle.
REQ-006 SHALL have ports wb_en (input, 1), wb_addr (input, 5) and wb_data (input, 32): writeback bypass, identical to the register-file write port.
REQ-007 SHALL have ports flush (input, 1) and out_ready (input, 1).
REQ-008 SHALL have registered outputs, all zero at reset:
- out_valid (1), out_pc (32), out_rs1_val (32), out_rs2_val (32), out_imm (32)
- out_rd (5), out_rd_we (1), out_opcode (7), out_funct3 (3), out_funct7b5 (1)
- out_is_load (1), out_illegal (1)

Function
REQ-009 SHALL drive addr1 = in_instr[19:15] and addr2 = in_instr[24:20] combinationally.
REQ-010 SHALL select each operand value by priority:
- address 0 -> 0;
- else wb_en=1 and wb_addr equal to the address -> wb_data;
- else datos1/datos2.
REQ-011 SHALL sign-extend the immediate to 32 bits by format:
- I-type: 0x03, 0x13, 0x67, 0x73
- S-type: 0x23
- B-type: 0x63, bit0=0
- U-type: 0x37, 0x17, low 12 bits = 0
- J-type: 0x6F, bit0=0
- R-type (0x33) and 0x0F: 0
REQ-012 SHALL set out_illegal=1, out_rd_we=0 for any opcode other than 0x37, 0x17, 0x6F, 0x67, 0x63, 0x03, 0x23, 0x13, 0x33, 0x0F, 0x73, or in_instr[1:0]!=2'b11.
REQ-013 SHALL set out_rd_we=1 only for opcodes 0x37, 0x17, 0x6F, 0x67, 0x03, 0x13, 0x33 with rd!=0.
REQ-014 SHALL treat rs1 as used for every opcode except 0x37, 0x17, 0x6F, and rs2 as used only for 0x33, 0x23, 0x63.
REQ-015 SHALL compute hazard = out_valid & out_is_load & out_rd!=0 & (used rs1 equals out_rd, or used rs2 equals out_rd).
REQ-016 SHALL drive in_ready = (!out_valid | out_ready) & !hazard & !flush.
REQ-017 SHALL update the output register on a rising edge as follows, in priority order:
- flush=1 -> out_valid<=0, input dropped;
- else if !out_valid | out_ready: in_valid & in_ready -> load decoded fields, out_valid<=1;
- otherwise (including hazard) -> out_valid<=0 (bubble);
- else (stalled) -> hold all outputs unchanged.
REQ-018 SHALL make a load-use dependency produce exactly one bubble cycle, then accept the dependent instruction.
REQ-019 SHALL keep all data outputs stable while out_valid=1 and out_ready=0.

Reset
REQ-020 SHALL on rst_n=0 asynchronously clear every registered output to 0, independent of clk.
REQ-021 SHALL on reset mid-stall discard the held instruction; after rst_n rises, the first acceptance needs in_valid and a clock edge.

Verification
REQ-022 SHALL cover: reset, in_instr=0x00500093 (addi x1,x0,5), out_ready=1 -> next edge out_valid=1, out_rd=1, out_imm=5, out_rd_we=1, out_rs1_val=0.
REQ-023 SHALL cover: in_instr=0xFE20AC23 (sw x2,-8(x1)), datos1=0x100, datos2=0xDEADBEEF -> out_imm=0xFFFFFFF8, out_rs2_val=0xDEADBEEF, out_rd_we=0.
REQ-024 SHALL cover: 0x0000A103 (lw x2,0(x1)) accepted, then 0x001101B3 (add x3,x2,x1) -> in_ready=0 one cycle, one bubble (out_valid=0), add issued on the following edge.
REQ-025 SHALL cover: wb_en=1, wb_addr=1, wb_data=0x12345678, datos1=0, add with rs1=x1 -> out_rs1_val=0x12345678; same with wb_addr=0 -> value 0.
REQ-026 SHALL cover: out_ready=0 for 3 cycles with out_valid=1 -> outputs constant and in_ready=0; then flush=1 -> out_valid=0 next edge.
REQ-027 SHALL cover: in_instr=0x0000007F -> out_illegal=1, out_rd_we=0.

Source files
------------

// File: rtl/etapa_decodificacion.sv
// Decode stage: field extraction, operand bypass, immediate build,
// load-use interlock and a single output register with valid/ready.
module etapa_decodificacion (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_instr,
   input  logic [31:0] in_pc,
   output logic [4:0]  addr1,
   output logic [4:0]  addr2,
   input  logic [31:0] datos1,
   input  logic [31:0] datos2,
   input  logic        wb_en,
   input  logic [4:0]  wb_addr,
   input  logic [31:0] wb_data,
   input  logic        flush,
   input  logic        out_ready,
   output logic        out_valid,
   output logic [31:0] out_pc,
   output logic [31:0] out_rs1_val,
   output logic [31:0] out_rs2_val,
   output logic [31:0] out_imm,
   output logic [4:0]  out_rd,
   output logic        out_rd_we,
   output logic [6:0]  out_opcode,
   output logic [2:0]  out_funct3,
   output logic        out_funct7b5,
   output logic        out_is_load,
   output logic        out_illegal
);

   localparam logic [6:0] OP_LUI   = 7'h37;
   localparam logic [6:0] OP_AUIPC = 7'h17;
   localparam logic [6:0] OP_JAL   = 7'h6F;
   localparam logic [6:0] OP_JALR  = 7'h67;
   localparam logic [6:0] OP_BR    = 7'h63;
   localparam logic [6:0] OP_LD    = 7'h03;
   localparam logic [6:0] OP_ST    = 7'h23;
   localparam logic [6:0] OP_IMM   = 7'h13;
   localparam logic [6:0] OP_REG   = 7'h33;
   localparam logic [6:0] OP_FENCE = 7'h0F;
   localparam logic [6:0] OP_SYS   = 7'h73;

   logic [6:0]  opcode;
   logic [4:0]  rd;
   logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
   logic [31:0] imm;
   logic        legal, writes, use1, use2;
   logic        hazard, advance, accept;
   logic [31:0] rs1_val, rs2_val;

   assign opcode = in_instr[6:0];
   assign rd     = in_instr[11:7];
   assign addr1  = in_instr[19:15];
   assign addr2  = in_instr[24:20];

   assign imm_i = {{20{in_instr[31]}}, in_instr[31:20]};
   assign imm_s = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
   assign imm_b = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                   in_instr[30:25], in_instr[11:8], 1'b0};
   assign imm_u = {in_instr[31:12], 12'b0};
   assign imm_j = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                   in_instr[20], in_instr[30:21], 1'b0};

   always_comb begin
      legal  = 1'b1;
      writes = 1'b0;
      use1   = 1'b1;
      use2   = 1'b0;
      imm    = '0;
      case (opcode)
         OP_LUI, OP_AUIPC: begin
            imm = imm_u; writes = 1'b1; use1 = 1'b0;
         end
         OP_JAL: begin
            imm = imm_j; writes = 1'b1; use1 = 1'b0;
         end
         OP_JALR, OP_LD, OP_IMM: begin
            imm = imm_i; writes = 1'b1;
         end
         OP_BR: begin
            imm = imm_b; use2 = 1'b1;
         end
         OP_ST: begin
            imm = imm_s; use2 = 1'b1;
         end
         OP_REG: begin
            writes = 1'b1; use2 = 1'b1;
         end
         OP_FENCE: ;
         OP_SYS: imm = imm_i;
         default: legal = 1'b0;
      endcase
   end

   // x0 reads as zero even if writeback targets it
   function automatic logic [31:0] bypass(
      input logic [4:0]  a,
      input logic [31:0] d,
      input logic        en,
      input logic [4:0]  wa,
      input logic [31:0] wd
   );
      if (a == 5'd0)           return '0;
      else if (en && wa == a)  return wd;
      else                     return d;
   endfunction

   assign rs1_val = bypass(addr1, datos1, wb_en, wb_addr, wb_data);
   assign rs2_val = bypass(addr2, datos2, wb_en, wb_addr, wb_data);

   assign hazard = out_valid && out_is_load && out_rd != 5'd0 &&
                   ((use1 && addr1 == out_rd) ||
                    (use2 && addr2 == out_rd));
   assign advance  = !out_valid || out_ready;
   assign in_ready = advance && !hazard && !flush;
   assign accept   = in_valid && in_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid    <= 1'b0;
         out_pc       <= '0;
         out_rs1_val  <= '0;
         out_rs2_val  <= '0;
         out_imm      <= '0;
         out_rd       <= '0;
         out_rd_we    <= 1'b0;
         out_opcode   <= '0;
         out_funct3   <= '0;
         out_funct7b5 <= 1'b0;
         out_is_load  <= 1'b0;
         out_illegal  <= 1'b0;
      end else if (flush) begin
         out_valid <= 1'b0;
      end else if (advance) begin
         if (accept) begin
            out_valid    <= 1'b1;
            out_pc       <= in_pc;
            out_rs1_val  <= rs1_val;
            out_rs2_val  <= rs2_val;
            out_imm      <= imm;
            out_rd       <= rd;
            out_rd_we    <= writes && rd != 5'd0;
            out_opcode   <= opcode;
            out_funct3   <= in_instr[14:12];
            out_funct7b5 <= in_instr[30];
            out_is_load  <= opcode == OP_LD;
            out_illegal  <= !legal;
         end else begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_etapa_decodificacion.sv
// Bench for etapa_decodificacion: directed cases then random traffic
// against a cycle-level reference model of the decode register.
module tb_etapa_decodificacion;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid, in_ready;
   logic [31:0] in_instr, in_pc;
   logic [4:0]  addr1, addr2;
   logic [31:0] datos1, datos2;
   logic        wb_en;
   logic [4:0]  wb_addr;
   logic [31:0] wb_data;
   logic        flush, out_ready;
   logic        out_valid;
   logic [31:0] out_pc, out_rs1_val, out_rs2_val, out_imm;
   logic [4:0]  out_rd;
   logic        out_rd_we;
   logic [6:0]  out_opcode;
   logic [2:0]  out_funct3;
   logic        out_funct7b5, out_is_load, out_illegal;

   int vectors = 0;
   int miscompares = 0;

   logic        m_valid, m_we, m_f7, m_load, m_ill;
   logic [31:0] m_pc, m_rs1, m_rs2, m_imm;
   logic [4:0]  m_rd;
   logic [6:0]  m_opc;
   logic [2:0]  m_f3;

   logic [31:0] snap_pc, snap_imm, snap_rs1;
   logic [4:0]  snap_rd;

   always #5 clk = ~clk;

   etapa_decodificacion dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_instr(in_instr), .in_pc(in_pc),
      .addr1(addr1), .addr2(addr2),
      .datos1(datos1), .datos2(datos2),
      .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
      .flush(flush), .out_ready(out_ready),
      .out_valid(out_valid), .out_pc(out_pc),
      .out_rs1_val(out_rs1_val), .out_rs2_val(out_rs2_val),
      .out_imm(out_imm), .out_rd(out_rd), .out_rd_we(out_rd_we),
      .out_opcode(out_opcode), .out_funct3(out_funct3),
      .out_funct7b5(out_funct7b5), .out_is_load(out_is_load),
      .out_illegal(out_illegal)
   );

   function automatic bit is_legal(input logic [6:0] o);
      return o inside {7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03,
                       7'h23, 7'h13, 7'h33, 7'h0F, 7'h73};
   endfunction

   function automatic bit is_writer(input logic [6:0] o);
      return o inside {7'h37, 7'h17, 7'h6F, 7'h67, 7'h03, 7'h13, 7'h33};
   endfunction

   function automatic bit uses_rs1(input logic [6:0] o);
      return !(o inside {7'h37, 7'h17, 7'h6F});
   endfunction

   function automatic bit uses_rs2(input logic [6:0] o);
      return o inside {7'h33, 7'h23, 7'h63};
   endfunction

   // immediates rebuilt with signed arithmetic on the instruction word
   function automatic logic [31:0] ref_imm(input logic [31:0] ins);
      int s;
      int sg;
      s  = $signed(ins);
      sg = s >>> 31;
      case (ins[6:0])
         7'h03, 7'h13, 7'h67, 7'h73: return s >>> 20;
         7'h23: return ((s >>> 25) * 32) + int'(ins[11:7]);
         7'h63: return sg * 4096 + int'(ins[7]) * 2048 +
                       int'(ins[30:25]) * 32 + int'(ins[11:8]) * 2;
         7'h37, 7'h17: return ins & 32'hFFFF_F000;
         7'h6F: return sg * 1048576 + int'(ins[19:12]) * 4096 +
                       int'(ins[20]) * 2048 + int'(ins[30:21]) * 2;
         default: return 32'd0;
      endcase
   endfunction

   function automatic logic [31:0] ref_op(input logic [4:0] a,
                                          input logic [31:0] d);
      if (a == 0) return 32'd0;
      if (wb_en && wb_addr == a) return wb_data;
      return d;
   endfunction

   function automatic logic [31:0] rand_instr();
      logic [31:0] r;
      r = $urandom;
      case ($urandom_range(0, 12))
         0: r[6:0] = 7'h37;
         1: r[6:0] = 7'h17;
         2: r[6:0] = 7'h6F;
         3: r[6:0] = 7'h67;
         4: r[6:0] = 7'h63;
         5: r[6:0] = 7'h03;
         6: r[6:0] = 7'h23;
         7: r[6:0] = 7'h13;
         8: r[6:0] = 7'h33;
         9: r[6:0] = 7'h0F;
         10: r[6:0] = 7'h73;
         default: ;
      endcase
      r[11:7]  = 5'($urandom_range(0, 3));
      r[19:15] = 5'($urandom_range(0, 3));
      r[24:20] = 5'($urandom_range(0, 3));
      return r;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_valid = 0; m_pc = 0; m_rs1 = 0; m_rs2 = 0; m_imm = 0;
      m_rd = 0; m_we = 0; m_opc = 0; m_f3 = 0; m_f7 = 0;
      m_load = 0; m_ill = 0;
   endtask

   task automatic check_outputs();
      chk("out_valid", out_valid, m_valid);
      chk("out_pc", out_pc, m_pc);
      chk("out_rs1_val", out_rs1_val, m_rs1);
      chk("out_rs2_val", out_rs2_val, m_rs2);
      chk("out_imm", out_imm, m_imm);
      chk("out_rd", out_rd, m_rd);
      chk("out_rd_we", out_rd_we, m_we);
      chk("out_opcode", out_opcode, m_opc);
      chk("out_funct3", out_funct3, m_f3);
      chk("out_funct7b5", out_funct7b5, m_f7);
      chk("out_is_load", out_is_load, m_load);
      chk("out_illegal", out_illegal, m_ill);
   endtask

   // called at a falling edge with inputs already applied
   task automatic cyc();
      logic [6:0] o;
      logic [4:0] r1, r2;
      bit hz, rdy;
      #1;
      o  = in_instr[6:0];
      r1 = in_instr[19:15];
      r2 = in_instr[24:20];
      hz = m_valid && m_load && m_rd != 0 &&
           ((uses_rs1(o) && r1 == m_rd) || (uses_rs2(o) && r2 == m_rd));
      rdy = (!m_valid || out_ready) && !hz && !flush;
      chk("addr1", addr1, r1);
      chk("addr2", addr2, r2);
      chk("in_ready", in_ready, rdy);
      if (flush) begin
         m_valid = 0;
      end else if (!m_valid || out_ready) begin
         if (in_valid && rdy) begin
            m_valid = 1;
            m_pc    = in_pc;
            m_rs1   = ref_op(r1, datos1);
            m_rs2   = ref_op(r2, datos2);
            m_imm   = is_legal(o) ? ref_imm(in_instr) : 32'd0;
            m_rd    = in_instr[11:7];
            m_we    = is_writer(o) && in_instr[11:7] != 0;
            m_opc   = o;
            m_f3    = in_instr[14:12];
            m_f7    = in_instr[30];
            m_load  = o == 7'h03;
            m_ill   = !is_legal(o);
         end else begin
            m_valid = 0;
         end
      end
      @(posedge clk);
      #1;
      check_outputs();
      @(negedge clk);
   endtask

   initial begin
      in_valid = 0; in_instr = 0; in_pc = 0;
      datos1 = 0; datos2 = 0;
      wb_en = 0; wb_addr = 0; wb_data = 0;
      flush = 0; out_ready = 1;
      rst_n = 0;
      model_reset();
      #2;
      check_outputs();
      @(negedge clk);
      rst_n = 1;

      // addi x1,x0,5
      in_valid = 1; in_instr = 32'h0050_0093; in_pc = 32'h100;
      cyc();
      chk("addi_valid", out_valid, 1);
      chk("addi_rd", out_rd, 1);
      chk("addi_imm", out_imm, 5);
      chk("addi_we", out_rd_we, 1);
      chk("addi_rs1", out_rs1_val, 0);

      // sw x2,-8(x1)
      in_instr = 32'hFE20_AC23; in_pc = 32'h104;
      datos1 = 32'h100; datos2 = 32'hDEAD_BEEF;
      cyc();
      chk("sw_imm", out_imm, 32'hFFFF_FFF8);
      chk("sw_rs2", out_rs2_val, 32'hDEAD_BEEF);
      chk("sw_we", out_rd_we, 0);

      // lw x2,0(x1) then add x3,x2,x1: one bubble
      in_instr = 32'h0000_A103; in_pc = 32'h108;
      cyc();
      in_instr = 32'h0011_01B3; in_pc = 32'h10C;
      #1 chk("lu_stall", in_ready, 0);
      cyc();
      chk("lu_bubble", out_valid, 0);
      #1 chk("lu_release", in_ready, 1);
      cyc();
      chk("lu_issue", out_valid, 1);
      chk("lu_opcode", out_opcode, 7'h33);

      // writeback bypass, and x0 never bypassed
      datos1 = 0; wb_en = 1; wb_addr = 1; wb_data = 32'h1234_5678;
      in_instr = 32'h0020_81B3;
      cyc();
      chk("byp_rs1", out_rs1_val, 32'h1234_5678);
      wb_addr = 0; datos1 = 32'h55; in_instr = 32'h0020_01B3;
      cyc();
      chk("byp_x0", out_rs1_val, 0);
      wb_en = 0;

      // stall for 3 cycles then flush
      in_instr = 32'h0050_0093; in_pc = 32'h200;
      cyc();
      snap_pc = out_pc; snap_imm = out_imm;
      snap_rs1 = out_rs1_val; snap_rd = out_rd;
      out_ready = 0; in_instr = 32'h0030_0113; in_pc = 32'h204;
      for (int i = 0; i < 3; i++) begin
         #1 chk("stall_ready", in_ready, 0);
         cyc();
         chk("stall_valid", out_valid, 1);
         chk("stall_pc", out_pc, snap_pc);
         chk("stall_imm", out_imm, snap_imm);
         chk("stall_rs1", out_rs1_val, snap_rs1);
         chk("stall_rd", out_rd, snap_rd);
      end
      flush = 1;
      cyc();
      chk("flush_valid", out_valid, 0);
      flush = 0; out_ready = 1;

      // reset while stalled drops the held instruction
      cyc();
      out_ready = 0;
      cyc();
      chk("pre_rst_valid", out_valid, 1);
      rst_n = 0;
      model_reset();
      #2;
      check_outputs();
      @(negedge clk);
      rst_n = 1; in_valid = 0; out_ready = 1;
      cyc();
      chk("post_rst_idle", out_valid, 0);
      in_valid = 1;
      cyc();
      chk("post_rst_accept", out_valid, 1);

      // illegal opcode and non-32-bit encoding
      in_instr = 32'h0000_007F;
      cyc();
      chk("ill_flag", out_illegal, 1);
      chk("ill_we", out_rd_we, 0);
      in_instr = 32'h0050_0090;
      cyc();
      chk("ill_low", out_illegal, 1);

      for (int i = 0; i < 400; i++) begin
         in_valid  = $urandom_range(0, 3) != 0;
         out_ready = $urandom_range(0, 3) != 0;
         flush     = $urandom_range(0, 15) == 0;
         wb_en     = 1'($urandom_range(0, 1));
         wb_addr   = 5'($urandom_range(0, 3));
         wb_data   = $urandom;
         datos1    = $urandom;
         datos2    = $urandom;
         in_pc     = $urandom;
         in_instr  = rand_instr();
         cyc();
      end

      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

endmodule
